// File: rtl/mod_amplitude_core.sv
// Amplitude-modulated tone generator.
// A sine carrier (phase increment freq_i) is multiplied by a slow sine
// envelope (fixed increment MOD_INC) and offset to unsigned 8-bit PCM.
// Pipeline: accumulators -> LUT registers -> product/output register.
module mod_amplitude_core #(
   parameter int PHASE_W = 27,
   parameter int MOD_INC = 21
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic [15:0] freq_i,
   output logic [7:0]  sample_data_o
);

   // First quadrant of round(127*sin(2*pi*k/256)), k = 0..64.
   function automatic logic [6:0] quarter_sine(input logic [6:0] a);
      logic [6:0] v;
      case (a)
         7'd0:  v = 7'd0;   7'd1:  v = 7'd3;   7'd2:  v = 7'd6;   7'd3:  v = 7'd9;
         7'd4:  v = 7'd12;  7'd5:  v = 7'd16;  7'd6:  v = 7'd19;  7'd7:  v = 7'd22;
         7'd8:  v = 7'd25;  7'd9:  v = 7'd28;  7'd10: v = 7'd31;  7'd11: v = 7'd34;
         7'd12: v = 7'd37;  7'd13: v = 7'd40;  7'd14: v = 7'd43;  7'd15: v = 7'd46;
         7'd16: v = 7'd49;  7'd17: v = 7'd51;  7'd18: v = 7'd54;  7'd19: v = 7'd57;
         7'd20: v = 7'd60;  7'd21: v = 7'd63;  7'd22: v = 7'd65;  7'd23: v = 7'd68;
         7'd24: v = 7'd71;  7'd25: v = 7'd73;  7'd26: v = 7'd76;  7'd27: v = 7'd78;
         7'd28: v = 7'd81;  7'd29: v = 7'd83;  7'd30: v = 7'd85;  7'd31: v = 7'd88;
         7'd32: v = 7'd90;  7'd33: v = 7'd92;  7'd34: v = 7'd94;  7'd35: v = 7'd96;
         7'd36: v = 7'd98;  7'd37: v = 7'd100; 7'd38: v = 7'd102; 7'd39: v = 7'd104;
         7'd40: v = 7'd106; 7'd41: v = 7'd107; 7'd42: v = 7'd109; 7'd43: v = 7'd111;
         7'd44: v = 7'd112; 7'd45: v = 7'd113; 7'd46: v = 7'd115; 7'd47: v = 7'd116;
         7'd48: v = 7'd117; 7'd49: v = 7'd118; 7'd50: v = 7'd120; 7'd51: v = 7'd121;
         7'd52: v = 7'd122; 7'd53: v = 7'd122; 7'd54: v = 7'd123; 7'd55: v = 7'd124;
         7'd56: v = 7'd125; 7'd57: v = 7'd125; 7'd58: v = 7'd126; 7'd59: v = 7'd126;
         7'd60: v = 7'd126; 7'd61: v = 7'd127; 7'd62: v = 7'd127; 7'd63: v = 7'd127;
         7'd64: v = 7'd127;
         default: v = 7'd0;
      endcase
      return v;
   endfunction

   // Full 256-point signed sine built from the quarter table by symmetry.
   function automatic logic signed [7:0] sine_lut(input logic [7:0] idx);
      logic [6:0]        addr;
      logic [6:0]        mag;
      logic signed [7:0] res;
      if (idx[6]) begin
         addr = 7'd64 - {1'b0, idx[5:0]};
      end else begin
         addr = {1'b0, idx[5:0]};
      end
      mag = quarter_sine(addr);
      if (idx[7]) begin
         res = -$signed({1'b0, mag});
      end else begin
         res = $signed({1'b0, mag});
      end
      return res;
   endfunction

   logic [PHASE_W-1:0] r_car_ph;
   logic [PHASE_W-1:0] r_mod_ph;
   logic signed [7:0]  r_car_ff;
   logic [8:0]         r_env_ff;

   logic signed [7:0]  w_car_lut;
   logic signed [7:0]  w_mod_lut;
   logic [8:0]         w_env;
   logic signed [15:0] w_car_ext;
   logic signed [15:0] w_env_ext;
   logic signed [15:0] w_prod;
   logic [7:0]         w_sample;
   logic               w_unused_lsb;

   assign w_car_lut = sine_lut(r_car_ph[PHASE_W-1 -: 8]);
   assign w_mod_lut = sine_lut(r_mod_ph[PHASE_W-1 -: 8]);
   // Envelope is the LFO sine lifted to 1..255; 9-bit wrap handles the offset.
   assign w_env     = {w_mod_lut[7], w_mod_lut} + 9'd128;

   // |car*env| <= 127*255, so a 16-bit signed product cannot overflow.
   assign w_car_ext = {{8{r_car_ff[7]}}, r_car_ff};
   assign w_env_ext = {7'd0, r_env_ff};
   assign w_prod    = w_car_ext * w_env_ext;
   // Bits 15:8 are the floor of p/256; adding 128 moves it to unsigned PCM.
   assign w_sample  = w_prod[15:8] + 8'd128;
   assign w_unused_lsb = ^w_prod[7:0];

   // Phase accumulators; silent modulo wrap keeps the LUT index continuous.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_car_ph <= '0;
         r_mod_ph <= '0;
      end else begin
         r_car_ph <= r_car_ph + PHASE_W'(freq_i);
         r_mod_ph <= r_mod_ph + PHASE_W'(MOD_INC);
      end
   end

   // Register carrier and envelope LUT outputs.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_car_ff <= 8'sd0;
         r_env_ff <= 9'd128;
      end else begin
         r_car_ff <= w_car_lut;
         r_env_ff <= w_env;
      end
   end

   // Register the modulated sample.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         sample_data_o <= 8'h80;
      end else begin
         sample_data_o <= w_sample;
      end
   end

endmodule

// File: tb/tb_mod_amplitude_core.sv
// Directed bench for mod_amplitude_core with PHASE_W = 23 so that
// freq_i = 32768 advances the LUT index by exactly one per clock.
module tb_mod_amplitude_core;

   logic       clk;
   logic       rstn;
   logic [15:0] freq_i;
   logic [7:0] sample_data_o;

   int n_checks;
   int n_fail;

   // Reference state: accumulators, LUT registers and expected output.
   logic [22:0] m_car;
   logic [22:0] m_mod;
   int          m_car_ff;
   int          m_env_ff;
   int          m_out;

   logic [7:0] rec [0:300];

   mod_amplitude_core #(.PHASE_W(23), .MOD_INC(21)) dut (
      .clk           (clk),
      .rstn          (rstn),
      .freq_i        (freq_i),
      .sample_data_o (sample_data_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic int ref_lut(input int idx);
      real v;
      v = 127.0 * $sin(2.0 * 3.14159265358979 * real'(idx) / 256.0);
      if (v >= 0.0) return $rtoi(v + 0.5);
      else return -$rtoi(0.5 - v);
   endfunction

   task automatic model_reset();
      m_car    = 23'd0;
      m_mod    = 23'd0;
      m_car_ff = 0;
      m_env_ff = 128;
      m_out    = 128;
   endtask

   // One clock: advance the reference exactly as the edge does, then compare.
   task automatic tick();
      @(posedge clk);
      m_out    = ((m_car_ff * m_env_ff) >>> 8) + 128;
      m_car_ff = ref_lut(int'(m_car[22:15]));
      m_env_ff = ref_lut(int'(m_mod[22:15])) + 128;
      m_car    = m_car + {7'd0, freq_i};
      m_mod    = m_mod + 23'd21;
      #1;
      check("model", sample_data_o, 8'(m_out));
   endtask

   // Asynchronous reset pulse placed between clock edges.
   task automatic pulse_reset(input string tag);
      #2;
      rstn = 1'b0;
      #1;
      check({tag, "_immediate"}, sample_data_o, 8'h80);
      model_reset();
      @(posedge clk);
      #1;
      check({tag, "_held"}, sample_data_o, 8'h80);
      @(negedge clk);
      rstn = 1'b1;
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rstn     = 1'b0;
      freq_i   = 16'd1234;
      model_reset();

      // Reset held for two cycles with a nonzero frequency.
      repeat (2) begin
         @(posedge clk);
         #1;
         check("reset", sample_data_o, 8'h80);
      end

      // Zero frequency: carrier phase stays at index 0, output stays midscale.
      freq_i = 16'd0;
      @(negedge clk);
      rstn = 1'b1;
      for (int i = 0; i < 10000; i++) begin
         tick();
         check("freeze0", sample_data_o, 8'h80);
      end

      // Index steps by one per clock; record the post-reset sequence.
      freq_i = 16'd32768;
      pulse_reset("rst_a");
      for (int k = 1; k <= 300; k++) begin
         tick();
         rec[k] = sample_data_o;
      end
      // Envelope is 128 here, so out = 128 + floor(LUT[k-2]/2).
      check("edge1",   rec[1],   8'd128);
      check("idx0",    rec[2],   8'd128);
      check("idx1",    rec[3],   8'd129);
      check("idx32",   rec[34],  8'd173);
      check("idx64",   rec[66],  8'd191);
      check("idx128",  rec[130], 8'd128);
      check("idx160",  rec[162], 8'd83);
      // floor(-127*128/256) = floor(-63.5) = -64
      check("idx192",  rec[194], 8'd64);
      check("wrap0",   rec[258], 8'd128);
      check("wrap1",   rec[259], 8'd129);

      // Phase-continuous frequency changes.
      freq_i = 16'd16384;
      repeat (200) tick();
      freq_i = 16'd32768;
      repeat (200) tick();
      freq_i = 16'd65535;
      repeat (100) tick();

      // Mid-run reset: the sequence must repeat bit-exactly.
      freq_i = 16'd32768;
      pulse_reset("rst_b");
      for (int k = 1; k <= 300; k++) begin
         tick();
         check("repeat", sample_data_o, rec[k]);
      end

      // Freeze the carrier at index 64 and let the envelope move.
      for (int k = 301; k <= 320; k++) tick();
      freq_i = 16'd0;
      for (int k = 321; k <= 20000; k++) begin
         tick();
         if (k == 400) check("frz64_env128", sample_data_o, 8'd191);
         if (k == 20000) check("frz64_env165", sample_data_o, 8'd209);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
